// File: rtl/racing_map_pkg.sv
// rtl/racing_map_pkg.sv - racing game memory map, flag bits and bus-master state encoding
package racing_map_pkg;

   localparam logic [7:0] RAM_PLAYER_X    = 8'h02;
   localparam logic [7:0] RAM_PLAYER_Y    = 8'h03;
   localparam logic [7:0] RAM_ENEMY_X     = 8'h04;
   localparam logic [7:0] RAM_ENEMY_Y     = 8'h05;
   localparam logic [7:0] RAM_ENEMY_DIR   = 8'h06;
   localparam logic [7:0] RAM_SPEED       = 8'h07;
   localparam logic [7:0] RAM_TRACKPOS_LO = 8'h08;
   localparam logic [7:0] RAM_TRACKPOS_HI = 8'h09;

   localparam logic [7:0] IO_VPOS  = 8'h41;
   localparam logic [7:0] IO_FLAGS = 8'h42;

   localparam int FLAG_HPADDLE   = 1;
   localparam int FLAG_VSYNC     = 4;
   localparam int FLAG_COLLISION = 5;

   localparam logic [2:0] INIT_LAST_IDX = 3'd5;

   typedef enum logic [4:0] {
      ST_INIT,
      ST_POLL_PAD,
      ST_RD_VPOS,
      ST_WR_PX,
      ST_VS_ON,
      ST_VS_OFF,
      ST_CHK_COLL,
      ST_WR_CSPD,
      ST_RD_SPD,
      ST_WR_SPD,
      ST_RD_TLO,
      ST_WR_TLO,
      ST_RD_THI,
      ST_WR_THI,
      ST_RD_EY,
      ST_WR_EY,
      ST_RD_EX,
      ST_RD_DIR,
      ST_WR_EX,
      ST_WR_DIR
   } state_e;

endpackage

// File: rtl/racing_bus_master.sv
// rtl/racing_bus_master.sv - FSM bus initiator that runs the racing game frame update in place of the CPU
module racing_bus_master
   import racing_map_pkg::*;
#(
   parameter int INIT_X        = 128,
   parameter int INIT_PLAYER_Y = 180,
   parameter int COLLIDE_SPEED = 16
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] address,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       write,
   output logic       frame_done
);

   state_e     state_q, state_d;
   logic [2:0] init_idx_q, init_idx_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] dir_q, dir_d;
   logic [3:0] spd16_q, spd16_d;
   logic       carry_q, carry_d;
   logic       frame_done_q, frame_done_d;

   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic [8:0] sum9;
   logic [7:0] spd_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_INIT;
         init_idx_q   <= 3'd0;
         acc_q        <= 8'h00;
         dir_q        <= 8'h00;
         spd16_q      <= 4'h0;
         carry_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         acc_q        <= acc_d;
         dir_q        <= dir_d;
         spd16_q      <= spd16_d;
         carry_q      <= carry_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      acc_d        = acc_q;
      dir_d        = dir_q;
      spd16_d      = spd16_q;
      carry_d      = carry_q;
      frame_done_d = 1'b0;
      bus_addr     = 8'h00;
      bus_wdata    = 8'h00;
      bus_we       = 1'b0;
      sum9         = 9'h000;
      spd_next     = 8'h00;

      case (state_q)
         ST_INIT: begin
            bus_we = 1'b1;
            case (init_idx_q)
               3'd0: begin bus_addr = RAM_PLAYER_X;  bus_wdata = 8'(INIT_X);        end
               3'd1: begin bus_addr = RAM_ENEMY_X;   bus_wdata = 8'(INIT_X);        end
               3'd2: begin bus_addr = RAM_ENEMY_Y;   bus_wdata = 8'(INIT_X);        end
               3'd3: begin bus_addr = RAM_PLAYER_Y;  bus_wdata = 8'(INIT_PLAYER_Y); end
               3'd4: begin bus_addr = RAM_SPEED;     bus_wdata = 8'h00;             end
               default: begin bus_addr = RAM_ENEMY_DIR; bus_wdata = 8'h01;          end
            endcase
            if (init_idx_q >= INIT_LAST_IDX) begin
               init_idx_d = 3'd0;
               state_d    = ST_POLL_PAD;
            end else begin
               init_idx_d = init_idx_q + 3'd1;
            end
         end
         ST_POLL_PAD: begin
            bus_addr = IO_FLAGS;
            if (data_in[FLAG_HPADDLE]) state_d = ST_RD_VPOS;
         end
         ST_RD_VPOS: begin
            bus_addr = IO_VPOS;
            acc_d    = data_in;
            state_d  = ST_WR_PX;
         end
         ST_WR_PX: begin
            bus_we    = 1'b1;
            bus_addr  = RAM_PLAYER_X;
            bus_wdata = acc_q;
            state_d   = ST_VS_ON;
         end
         ST_VS_ON: begin
            bus_addr = IO_FLAGS;
            if (data_in[FLAG_VSYNC]) state_d = ST_VS_OFF;
         end
         ST_VS_OFF: begin
            bus_addr = IO_FLAGS;
            if (!data_in[FLAG_VSYNC]) state_d = ST_CHK_COLL;
         end
         ST_CHK_COLL: begin
            bus_addr = IO_FLAGS;
            state_d  = data_in[FLAG_COLLISION] ? ST_WR_CSPD : ST_RD_SPD;
         end
         ST_WR_CSPD: begin
            bus_we    = 1'b1;
            bus_addr  = RAM_SPEED;
            bus_wdata = 8'(COLLIDE_SPEED);
            state_d   = ST_RD_SPD;
         end
         ST_RD_SPD: begin
            bus_addr = RAM_SPEED;
            spd_next = (data_in == 8'hFF) ? 8'hFF : data_in + 8'd1;
            acc_d    = spd_next;
            spd16_d  = spd_next[7:4];
            state_d  = ST_WR_SPD;
         end
         ST_WR_SPD: begin
            bus_we    = 1'b1;
            bus_addr  = RAM_SPEED;
            bus_wdata = acc_q;
            state_d   = ST_RD_TLO;
         end
         ST_RD_TLO: begin
            bus_addr = RAM_TRACKPOS_LO;
            sum9     = {1'b0, data_in} + {5'b00000, spd16_q};
            acc_d    = sum9[7:0];
            carry_d  = sum9[8];
            state_d  = ST_WR_TLO;
         end
         ST_WR_TLO: begin
            bus_we    = 1'b1;
            bus_addr  = RAM_TRACKPOS_LO;
            bus_wdata = acc_q;
            state_d   = carry_q ? ST_RD_THI : ST_RD_EY;
         end
         ST_RD_THI: begin
            bus_addr = RAM_TRACKPOS_HI;
            acc_d    = data_in + 8'd1;
            state_d  = ST_WR_THI;
         end
         ST_WR_THI: begin
            bus_we    = 1'b1;
            bus_addr  = RAM_TRACKPOS_HI;
            bus_wdata = acc_q;
            state_d   = ST_RD_EY;
         end
         ST_RD_EY: begin
            bus_addr = RAM_ENEMY_Y;
            acc_d    = data_in + {4'h0, spd16_q};
            state_d  = ST_WR_EY;
         end
         ST_WR_EY: begin
            bus_we    = 1'b1;
            bus_addr  = RAM_ENEMY_Y;
            bus_wdata = acc_q;
            state_d   = ST_RD_EX;
         end
         ST_RD_EX: begin
            bus_addr = RAM_ENEMY_X;
            acc_d    = data_in;
            state_d  = ST_RD_DIR;
         end
         ST_RD_DIR: begin
            // two's complement direction: plain 8-bit add moves left for 0xFF
            bus_addr = RAM_ENEMY_DIR;
            dir_d    = data_in;
            acc_d    = acc_q + data_in;
            state_d  = ST_WR_EX;
         end
         ST_WR_EX: begin
            bus_we    = 1'b1;
            bus_addr  = RAM_ENEMY_X;
            bus_wdata = acc_q;
            if (((acc_q - 8'd64) & 8'h7F) == 8'h00) begin
               state_d = ST_WR_DIR;
            end else begin
               frame_done_d = 1'b1;
               state_d      = ST_POLL_PAD;
            end
         end
         ST_WR_DIR: begin
            bus_we       = 1'b1;
            bus_addr     = RAM_ENEMY_DIR;
            bus_wdata    = 8'h00 - dir_q;
            frame_done_d = 1'b1;
            state_d      = ST_POLL_PAD;
         end
         default: begin
            state_d    = ST_INIT;
            init_idx_d = 3'd0;
         end
      endcase
   end

   // INIT decodes as a write state, so reset must mask the bus to keep it idle
   assign address    = reset ? 8'h00 : bus_addr;
   assign data_out   = reset ? 8'h00 : bus_wdata;
   assign write      = reset ? 1'b0  : bus_we;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_racing_bus_master.sv
// tb/tb_racing_bus_master.sv - self-checking bench for racing_bus_master with a RAM/IO responder
module tb_racing_bus_master;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       write;
   logic       frame_done;

   logic [7:0] ram [0:255];
   logic [7:0] vpos;
   logic       hp;
   logic       coll;
   logic       vs = 1'b0;

   logic       ld;
   logic [7:0] ld_spd, ld_tlo, ld_thi, ld_ey, ld_ex, ld_dir;

   int n_cmp;
   int n_fail;

   typedef struct {
      int vpos, spd, tlo, thi, ey, ex, dir, coll;
      int e_spd, e_tlo, e_thi, e_ey, e_ex, e_dir;
   } vec_t;

   vec_t vecs [6];

   racing_bus_master dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .data_in    (data_in),
      .data_out   (data_out),
      .write      (write),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   assign data_in = (address == 8'h41) ? vpos :
                    (address == 8'h42) ? {2'b00, coll, vs, 2'b00, hp, 1'b0} :
                    ram[address];

   always @(posedge clk) begin
      vs <= ~vs;
      if (write) ram[address] <= data_out;
      if (ld) begin
         ram[7] <= ld_spd;
         ram[8] <= ld_tlo;
         ram[9] <= ld_thi;
         ram[5] <= ld_ey;
         ram[4] <= ld_ex;
         ram[6] <= ld_dir;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load(input int spd, input int tlo, input int thi, input int ey, input int ex, input int dir);
      ld_spd = 8'(spd); ld_tlo = 8'(tlo); ld_thi = 8'(thi);
      ld_ey  = 8'(ey);  ld_ex  = 8'(ex);  ld_dir = 8'(dir);
      ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (frame_done) begin
            ok = 1'b1;
            break;
         end
      end
      hp = 1'b0;
      check("frame_done_seen", int'(ok), 1);
   endtask

   task automatic run_frame();
      hp = 1'b1;
      wait_done();
   endtask

   task automatic check_ram(input int px, input int spd, input int tlo, input int thi,
                            input int ey, input int ex, input int dir);
      check("player_x", int'(ram[2]), px);
      check("speed", int'(ram[7]), spd);
      check("trackpos_lo", int'(ram[8]), tlo);
      check("trackpos_hi", int'(ram[9]), thi);
      check("enemy_y", int'(ram[5]), ey);
      check("enemy_x", int'(ram[4]), ex);
      check("enemy_dir", int'(ram[6]), dir);
   endtask

   function automatic void model(input int spd, input int tlo, input int thi, input int ey,
                                 input int ex, input int dir, input int c,
                                 output int e_spd, output int e_tlo, output int e_thi,
                                 output int e_ey, output int e_ex, output int e_dir);
      int s, q, t;
      s = (c != 0) ? 16 : spd;
      s = (s < 255) ? s + 1 : 255;
      q = s / 16;
      t = tlo + q;
      e_spd = s;
      e_tlo = t % 256;
      e_thi = (t > 255) ? (thi + 1) % 256 : thi;
      e_ey  = (ey + q) % 256;
      e_ex  = (ex + dir) % 256;
      e_dir = (e_ex == 64 || e_ex == 192) ? (256 - dir) % 256 : dir;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int init_addr [6];
      int init_data [6];
      int e_spd, e_tlo, e_thi, e_ey, e_ex, e_dir;
      int r_spd, r_tlo, r_thi, r_ey, r_ex, r_dir, r_c, r_vp;
      int ey_before;
      bit hit;

      n_cmp = 0; n_fail = 0;
      reset = 1'b1; hp = 1'b0; coll = 1'b0; vpos = 8'd0; ld = 1'b0;
      ld_spd = 8'd0; ld_tlo = 8'd0; ld_thi = 8'd0; ld_ey = 8'd0; ld_ex = 8'd0; ld_dir = 8'd0;

      init_addr = '{2, 4, 5, 3, 7, 6};
      init_data = '{128, 128, 128, 180, 0, 1};

      vecs[0] = '{10, 255, 250, 255,  10, 100,   1, 0, 255,   9, 0,  25, 101,   1};
      vecs[1] = '{20, 200,   0,   0,   0,  50,   1, 1,  17,   1, 0,   1,  51,   1};
      vecs[2] = '{30,   0,   5,   3,   7, 191,   1, 0,   1,   5, 3,   7, 192, 255};
      vecs[3] = '{40,  15, 255,   7, 255,  65, 255, 0,  16,   0, 8,   0,  64,   1};
      vecs[4] = '{50, 254, 241,   0, 100,   0, 255, 0, 255,   0, 1, 115, 255, 255};
      vecs[5] = '{60,  31,  10,   9, 254, 193, 255, 0,  32,  12, 9,   0, 192,   1};

      // reset state and INIT write order
      repeat (3) @(negedge clk);
      #1;
      check("rst_address", int'(address), 0);
      check("rst_data_out", int'(data_out), 0);
      check("rst_write", int'(write), 0);
      check("rst_frame_done", int'(frame_done), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("init_write", int'(write), 1);
         check("init_address", int'(address), init_addr[i]);
         check("init_data", int'(data_out), init_data[i]);
         @(negedge clk);
      end
      #1;
      check("poll_address", int'(address), 8'h42);
      check("poll_write", int'(write), 0);
      @(negedge clk);

      // PLAYER_X written two cycles after hpaddle is first sampled
      load(0, 0, 0, 128, 128, 1);
      vpos = 8'd77;
      hp = 1'b1;
      @(negedge clk);
      check("rd_vpos_address", int'(address), 8'h41);
      check("rd_vpos_write", int'(write), 0);
      @(negedge clk);
      check("wr_px_write", int'(write), 1);
      check("wr_px_address", int'(address), 2);
      check("wr_px_data", int'(data_out), 77);
      wait_done();
      check("px_after_frame", int'(ram[2]), 77);

      // table-driven frames
      for (int i = 0; i < 6; i++) begin
         load(vecs[i].spd, vecs[i].tlo, vecs[i].thi, vecs[i].ey, vecs[i].ex, vecs[i].dir);
         vpos = 8'(vecs[i].vpos);
         coll = 1'(vecs[i].coll);
         run_frame();
         check_ram(vecs[i].vpos, vecs[i].e_spd, vecs[i].e_tlo, vecs[i].e_thi,
                   vecs[i].e_ey, vecs[i].e_ex, vecs[i].e_dir);
      end
      coll = 1'b0;

      // bounce at 192 then move back without a second reversal
      load(0, 0, 0, 0, 191, 1);
      run_frame();
      check("bounce_ex", int'(ram[4]), 192);
      check("bounce_dir", int'(ram[6]), 255);
      run_frame();
      check("after_bounce_ex", int'(ram[4]), 191);
      check("after_bounce_dir", int'(ram[6]), 255);

      // randomized frames against the reference model
      for (int n = 0; n < 40; n++) begin
         r_spd = (n % 5 == 0) ? 255 : int'($urandom_range(0, 255));
         r_tlo = int'($urandom_range(0, 255));
         r_thi = int'($urandom_range(0, 255));
         r_ey  = int'($urandom_range(0, 255));
         r_ex  = (n % 4 == 1) ? 63 : int'($urandom_range(0, 255));
         r_dir = (n % 2 == 0) ? 1 : 255;
         r_c   = int'($urandom_range(0, 1));
         r_vp  = int'($urandom_range(0, 255));
         model(r_spd, r_tlo, r_thi, r_ey, r_ex, r_dir, r_c, e_spd, e_tlo, e_thi, e_ey, e_ex, e_dir);
         load(r_spd, r_tlo, r_thi, r_ey, r_ex, r_dir);
         vpos = 8'(r_vp);
         coll = 1'(r_c);
         run_frame();
         check_ram(r_vp, e_spd, e_tlo, e_thi, e_ey, e_ex, e_dir);
      end
      coll = 1'b0;

      // reset during the ENEMY_Y write cycle
      load(40, 0, 0, 33, 10, 1);
      hp = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (write && address == 8'h05) begin
            hit = 1'b1;
            break;
         end
      end
      check("wr_ey_reached", int'(hit), 1);
      ey_before = int'(ram[5]);
      reset = 1'b1;
      hp = 1'b0;
      #1;
      check("midreset_write", int'(write), 0);
      check("midreset_address", int'(address), 0);
      @(posedge clk);
      #1;
      check("midreset_no_partial_write", int'(ram[5]), ey_before);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reinit_write", int'(write), 1);
      check("reinit_address", int'(address), 2);
      check("reinit_data", int'(data_out), 128);
      repeat (8) @(negedge clk);
      check("reinit_enemy_y", int'(ram[5]), 128);
      check("reinit_player_y", int'(ram[3]), 180);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/racing_bus_master.md
RACING_BUS_MASTER -- requirements
Module: racing_bus_master

Interface
REQ-001 Parameters SHALL be:
- INIT_X, 128, initial PLAYER_X/ENEMY_X/ENEMY_Y.
- INIT_PLAYER_Y, 180, initial PLAYER_Y.
- COLLIDE_SPEED, 16, speed forced on collision.
REQ-002 Ports SHALL be:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  out  8  bus address.
- data_in  in  8  read data, combinationally valid in the same cycle as address.
- data_out  out  8  write data.
- write  out  1  write strobe; the responder captures data_out at the posedge.
- frame_done  out  1  one-cycle pulse when a frame update completes.

Function
REQ-003 The block SHALL be a hardware bus initiator that replaces the 8-bit CPU on the racing game memory map.
- RAM offsets: PLAYER_X=2, PLAYER_Y=3, ENEMY_X=4, ENEMY_Y=5, ENEMY_DIR=6, SPEED=7, TRACKPOS_LO=8, TRACKPOS_HI=9.
- I/O: IN_VPOS=0x41, IN_FLAGS=0x42; flag bit1=hpaddle, bit4=vsync, bit5=collision.
REQ-004 Each state SHALL perform exactly one bus access per cycle.
- Read states sample data_in at the posedge that ends the cycle.
- Write states hold write=1 with address and data_out stable for that one cycle.
- write SHALL be 0 in every non-write state.
REQ-005 INIT SHALL write, one per cycle in this order: PLAYER_X=INIT_X, ENEMY_X=INIT_X, ENEMY_Y=INIT_X, PLAYER_Y=INIT_PLAYER_Y, SPEED=0, ENEMY_DIR=1. It then goes to POLL_PAD.
REQ-006 POLL_PAD SHALL read IN_FLAGS and repeat until bit1=1.
- RD_VPOS reads IN_VPOS into the accumulator.
- WR_PX writes the accumulator to PLAYER_X.
REQ-007 Vsync SHALL be handled in two states:
- VS_ON reads IN_FLAGS until bit4=1.
- VS_OFF reads IN_FLAGS until bit4=0.
- Each test uses the flags read in the same cycle; no extra sample is taken.
REQ-008 CHK_COLL SHALL read IN_FLAGS.
- If bit5=1, go to WR_CSPD, which writes SPEED=COLLIDE_SPEED, then to RD_SPD.
- Otherwise go straight to RD_SPD.
REQ-009 RD_SPD/WR_SPD SHALL read SPEED and write min(SPEED+1, 255); SPEED saturates and never wraps to 0. The block latches spd16 = new_speed >> 4 (4 bits).
REQ-010 RD_TLO/WR_TLO SHALL write TRACKPOS_LO = (TRACKPOS_LO + spd16) mod 256.
- On a 9-bit carry-out, RD_THI/WR_THI write TRACKPOS_HI+1 (wraps 255 to 0).
- With no carry, the TRACKPOS_HI states are skipped.
REQ-011 RD_EY/WR_EY SHALL write ENEMY_Y = (ENEMY_Y + spd16) mod 256.
REQ-012 RD_EX, RD_DIR, WR_EX SHALL write ENEMY_X = (ENEMY_X + ENEMY_DIR) mod 256, with ENEMY_DIR treated as two's complement.
- If ((new_x - 64) & 127) == 0, i.e. new_x is 64 or 192, WR_DIR writes ENEMY_DIR = (0 - dir) mod 256.
- Otherwise WR_DIR is skipped.
REQ-013 On leaving the last update state, frame_done SHALL pulse high for exactly one cycle and the FSM SHALL return to POLL_PAD. INIT is not re-entered.
REQ-014 All outputs SHALL be registered or decoded purely from state and internal registers; data_in SHALL NOT reach any output combinationally.

Reset
REQ-015 While reset is asserted:
- The FSM is in INIT with the INIT index at 0.
- address=0, data_out=0, write=0, frame_done=0.
- The accumulator, spd16 and carry are 0.
REQ-016 Reset asserted mid-frame (including during a write cycle) SHALL drop write within the same cycle. After release, the block restarts at INIT with no partial write.

Structure
REQ-017 The RAM offsets, I/O addresses, flag bit positions and state encoding SHALL live in a shared package, racing_map_pkg, which the top also uses.
REQ-018 No sub-module is needed. The adder/negate datapath SHALL stay inline in one FSM block of about 250 lines.

Verification
REQ-019 Reset release -> the first six cycles write (2,128), (4,128), (5,128), (3,180), (7,0), (6,1) in that order, then address=0x42 with write=0.
REQ-020 Flags=0x02 with IN_VPOS=77 -> PLAYER_X is written to 77 exactly two cycles after bit1 is first sampled high.
REQ-021 SPEED=255, TRACKPOS_LO=250, TRACKPOS_HI=255, no collision -> SPEED stays 255, TRACKPOS_LO=9, TRACKPOS_HI=0, ENEMY_Y increases by 15.
REQ-022 Collision flag set with SPEED=200 -> 16 is written first, then SPEED=17, spd16=1.
REQ-023 ENEMY_X=191, DIR=1 -> ENEMY_X=192 and DIR=0xFF. Next frame: ENEMY_X=191 with no reversal.
REQ-024 Reset pulsed in the cycle WR_EY is active -> write=0 immediately and the INIT sequence repeats from PLAYER_X.
